// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//
// Turns the debounced level of one button into single-cycle user events
// (press, release, long press, auto-repeat) plus a held level and a count
// of repeats since the last press. The input is already synchronized and
// debounced, so there is no synchronizer here.
//
// Parameters:
//   CNT_W          width of the hold-time counter
//   LONG_CYCLES    cycles from the press strobe to the long_press strobe (>= 2)
//   REPEAT_CYCLES  cycles between repeat strobes, and from long_press to the
//                  first repeat (>= 1)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   dbd          in   debounced button level, 1 = pressed
//   press        out  one-cycle strobe on an accepted press
//   release_evt  out  one-cycle strobe on release of an accepted press
//   long_press   out  one-cycle strobe after LONG_CYCLES of holding
//   repeat_evt   out  one-cycle strobe every REPEAT_CYCLES after long_press
//   held         out  high from the press cycle through the cycle before release
//   repeat_cnt   out  repeat strobes since the last press, saturating at 255
//
// "release" and "repeat" are reserved words in SystemVerilog, hence the
// _evt suffix on those two strobes.
// ---------------------------------------------------------------------------
module button_event #(
  parameter int CNT_W         = 26,
  parameter int LONG_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dbd,
  output logic       press,
  output logic       release_evt,
  output logic       long_press,
  output logic       repeat_evt,
  output logic       held,
  output logic [7:0] repeat_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // The press edge itself clears cnt, so the cycle carrying the press strobe
  // has cnt=0 and the edge that launches long_press sees cnt=LONG_CYCLES-1.
  // That lands long_press exactly LONG_CYCLES cycles after press. The same
  // reasoning gives REPEAT_CYCLES-1 for the repeat period.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic             dbd_q, dbd_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             rpt_q, rpt_d;
  logic             held_q, held_d;

  logic rise;
  logic fall;

  assign rise = dbd & ~dbd_q;
  assign fall = ~dbd & dbd_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    held_d    = held_q;
    dbd_d     = dbd;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    rpt_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A fall here belongs to a press we never accepted; ignore it.
        if (rise) begin
          press_d = 1'b1;
          held_d  = 1'b1;
          cnt_d   = '0;
          rcnt_d  = 8'd0;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        // Release is tested first so it wins over a coincident long_press.
        if (fall) begin
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_REPEAT: begin
        if (fall) begin
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (cnt_q == REPEAT_LAST) begin
          rpt_d  = 1'b1;
          cnt_d  = '0;
          rcnt_d = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  // Loading dbd_q from dbd during reset means a button held through reset
  // never looks like a rise; it has to be released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rcnt_q    <= 8'd0;
      dbd_q     <= dbd;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      dbd_q     <= dbd_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      rpt_q     <= rpt_d;
      held_q    <= held_d;
    end
  end

  assign press       = press_q;
  assign release_evt = release_q;
  assign long_press  = long_q;
  assign repeat_evt  = rpt_q;
  assign held        = held_q;
  assign repeat_cnt  = rcnt_q;

endmodule

// File: tb/tb_button_event.sv
module tb_button_event;

  localparam int L = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dbd = 1'b0;
  logic       press, release_evt, long_press, repeat_evt, held;
  logic [7:0] repeat_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       press;
    logic       rel;
    logic       lp;
    logic       rpt;
    logic       held;
    logic [7:0] rc;
  } exp_t;

  typedef struct {
    int hold;
    int exp_long;
    int exp_rpts;
  } vec_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   obs_press, obs_rel, obs_long, obs_rpt;

  button_event #(
    .CNT_W(8),
    .LONG_CYCLES(L),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dbd(dbd),
    .press(press),
    .release_evt(release_evt),
    .long_press(long_press),
    .repeat_evt(repeat_evt),
    .held(held),
    .repeat_cnt(repeat_cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs t cycles after the press strobe, for a button whose
  // dbd is sampled high on h consecutive edges (t = 0 is the press cycle).
  function automatic exp_t exp_at(input int t, input int h);
    exp_t e;
    int   m;
    int   n;
    e       = '0;
    e.press = (t == 0);
    e.rel   = (t == h);
    e.held  = (t < h);
    e.lp    = (t == L) && (t < h);
    e.rpt   = (t > L) && (t < h) && (((t - L) % R) == 0);
    m       = (t < h - 1) ? t : h - 1;
    n       = (m >= L + R) ? (m - L) / R : 0;
    e.rc    = (n > 255) ? 8'd255 : 8'(n);
    return e;
  endfunction

  // Drive one cycle of stimulus, queue what the DUT must show after the next
  // edge, then pop and compare once the edge has passed.
  task automatic step(input logic r, input logic d, input exp_t e, input string nm);
    exp_t want;
    exp_t got;
    @(negedge clk);
    rst = r;
    dbd = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    want = exp_q.pop_front();
    got  = {press, release_evt, long_press, repeat_evt, held, repeat_cnt};
    obs_press += int'(press);
    obs_rel   += int'(release_evt);
    obs_long  += int'(long_press);
    obs_rpt   += int'(repeat_evt);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc%0d got p%0b r%0b l%0b t%0b h%0b c%0d want p%0b r%0b l%0b t%0b h%0b c%0d",
               nm, cyc, got.press, got.rel, got.lp, got.rpt, got.held, got.rc,
               want.press, want.rel, want.lp, want.rpt, want.held, want.rc);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Press with dbd sampled high on h edges, then low; two idle cycles after.
  task automatic run_press(input int h, input int exp_long, input int exp_rpts, input string nm);
    obs_press = 0;
    obs_rel   = 0;
    obs_long  = 0;
    obs_rpt   = 0;
    for (int t = 0; t <= h + 2; t++)
      step(1'b0, (t < h), exp_at(t, h), nm);
    check_int({nm, "_npress"}, obs_press, 1);
    check_int({nm, "_nrel"},   obs_rel,   1);
    check_int({nm, "_nlong"},  obs_long,  exp_long);
    check_int({nm, "_nrpt"},   obs_rpt,   exp_rpts);
    check_int({nm, "_rcfin"},  int'(repeat_cnt), (exp_rpts > 255) ? 255 : exp_rpts);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{hold: 3,    exp_long: 0, exp_rpts: 0};   // short press
    vecs[1] = '{hold: 1,    exp_long: 0, exp_rpts: 0};   // one-cycle pulse
    vecs[2] = '{hold: 8,    exp_long: 0, exp_rpts: 0};   // release beats long_press
    vecs[3] = '{hold: 9,    exp_long: 1, exp_rpts: 0};
    vecs[4] = '{hold: 12,   exp_long: 1, exp_rpts: 0};   // release beats 1st repeat
    vecs[5] = '{hold: 13,   exp_long: 1, exp_rpts: 1};
    vecs[6] = '{hold: 20,   exp_long: 1, exp_rpts: 2};
    vecs[7] = '{hold: 16,   exp_long: 1, exp_rpts: 1};   // release beats repeat at P+16
    vecs[8] = '{hold: 17,   exp_long: 1, exp_rpts: 2};
    vecs[9] = '{hold: 1200, exp_long: 1, exp_rpts: 297}; // repeat_cnt saturates

    // Reset state with dbd low.
    step(1'b1, 1'b0, '0, "reset0");
    step(1'b1, 1'b0, '0, "reset1");
    step(1'b0, 1'b0, '0, "idle");

    for (int i = 0; i < 10; i++)
      run_press(vecs[i].hold, vecs[i].exp_long, vecs[i].exp_rpts, $sformatf("vec%0d", i));

    // Button held through reset: no press, and the later fall is ignored.
    step(1'b1, 1'b1, '0, "rsthi_rst");
    step(1'b1, 1'b1, '0, "rsthi_rst");
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, '0, "rsthi_hold");
    step(1'b0, 1'b0, '0, "rsthi_fall");
    run_press(3, 0, 0, "rsthi_press");

    // Reset during REPEAT aborts without a release; a new press needs a new rise.
    for (int t = 0; t <= 10; t++)
      step(1'b0, 1'b1, exp_at(t, 2000), "midrst_hold");
    step(1'b1, 1'b1, '0, "midrst_rst");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, '0, "midrst_after");
    step(1'b0, 1'b0, '0, "midrst_fall");
    run_press(3, 0, 0, "midrst_press");

    check_int("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
